// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma output path.
package enigma_pkg;

  localparam int ALPHA_N = 26;

  typedef logic [4:0] sym_t;

  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Letter code 0..25 to uppercase ASCII.
  function automatic logic [7:0] sym_to_ascii(input sym_t s);
    return ASCII_A + {3'b000, s};
  endfunction

endpackage

// File: rtl/enigma_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit.
// Bit timing counts only cycles where ena is high; ena low freezes the frame.
// done is high during the final stop-bit cycle, so the caller can load the
// next byte after exactly one idle cycle.
module enigma_uart_tx
  import enigma_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);
  assign done    = ena && (state == TX_STOP) && bit_end;

  // Frame sequencer: state, baud counter, bit index and the line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TX_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (ena) begin
      case (state)
        TX_IDLE: begin
          if (load) begin
            state    <= TX_START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
          end
        end
        TX_START: begin
          if (bit_end) begin
            state    <= TX_DATA;
            tx       <= shreg[0];
            bit_idx  <= '0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            state    <= TX_IDLE;
            busy     <= 1'b0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  // Data shifter: captured on load, shifted right at each data-bit boundary.
  always_ff @(posedge clk) begin
    if (ena) begin
      if (state == TX_IDLE && load) begin
        shreg <= data;
      end else if (state == TX_DATA && bit_end) begin
        shreg <= {1'b0, shreg[7:1]};
      end
    end
  end

endmodule

// File: rtl/enigma_out_grouper.sv
// Enigma output grouper: buffers core letters in a FIFO, converts them to
// ASCII, inserts a space after every GROUP_LEN letters and sends the stream
// over an 8N1 UART. Separators are sent lazily (only when another letter is
// waiting), so the stream never ends in a separator.
// Optional build macro ENIGMA_NEWLINE_EN: every LINE_GROUPS-th separator is
// sent as CR LF instead of a space.
module enigma_out_grouper
  import enigma_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8,
  parameter int GROUP_LEN    = 5,
  parameter int LINE_GROUPS  = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [4:0]                  in_sym,
  input  logic                        in_valid,
  input  logic                        grp_clr,
  output logic                        in_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        tx,
  output logic                        tx_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (CLKS_PER_BIT < 4) begin : g_chk_cpb
    $error("CLKS_PER_BIT must be at least 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (GROUP_LEN < 1 || GROUP_LEN > 15) begin : g_chk_grp
    $error("GROUP_LEN must be in 1..15");
  end
  if (LINE_GROUPS < 1 || LINE_GROUPS > 15) begin : g_chk_line
    $error("LINE_GROUPS must be in 1..15");
  end

  sym_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] lvl_nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             sym_ok;
  logic             push;
  logic             pop;
  logic             load;
  logic [7:0]       tx_char;
  logic [7:0]       letter_char;
  logic [7:0]       sep_char;
  logic             sep_due;
  logic [3:0]       grp_cnt;
  logic             chan_free;
  logic             tx_done;
`ifdef ENIGMA_NEWLINE_EN
  logic [3:0]       line_cnt;
  logic             lf_pend;
  logic             line_last;
`endif

  assign fifo_full   = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_level == '0);
  assign sym_ok      = (in_sym < sym_t'(ALPHA_N));
  assign push        = ena && in_valid && sym_ok && !fifo_full;
  assign letter_char = sym_to_ascii(mem[rd_ptr]);
  assign sep_due     = (grp_cnt == 4'(GROUP_LEN));

`ifdef ENIGMA_NEWLINE_EN
  assign line_last = (line_cnt == 4'(LINE_GROUPS - 1));
  assign sep_char  = line_last ? ASCII_CR : ASCII_SP;
`else
  assign sep_char  = ASCII_SP;
`endif

  // Idle-time decision: what to send next and whether it consumes a letter.
  always_comb begin
    load    = 1'b0;
    pop     = 1'b0;
    tx_char = letter_char;
    if (ena && chan_free) begin
      if (grp_clr) begin
        load = !fifo_empty;
        pop  = !fifo_empty;
      end
`ifdef ENIGMA_NEWLINE_EN
      else if (lf_pend) begin
        load    = 1'b1;
        tx_char = ASCII_LF;
      end
`endif
      else if (!fifo_empty) begin
        load = 1'b1;
        if (sep_due) begin
          tx_char = sep_char;
        end else begin
          pop = 1'b1;
        end
      end
    end
  end

  // Next occupancy; full is judged on the current level, before any pop.
  always_comb begin
    lvl_nxt = fifo_level;
    if (push && !pop) begin
      lvl_nxt = fifo_level + 1'b1;
    end else if (pop && !push) begin
      lvl_nxt = fifo_level - 1'b1;
    end
  end

  // FIFO control: pointers, occupancy, ready and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      in_ready   <= 1'b1;
      overflow   <= 1'b0;
    end else if (ena) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= lvl_nxt;
      in_ready   <= (lvl_nxt != LVL_W'(FIFO_DEPTH));
      if (in_valid && sym_ok && fifo_full) overflow <= 1'b1;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_sym;
  end

  // Grouping state: channel availability, group and line counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      chan_free <= 1'b1;
      grp_cnt   <= '0;
`ifdef ENIGMA_NEWLINE_EN
      line_cnt  <= '0;
      lf_pend   <= 1'b0;
`endif
    end else if (ena) begin
      if (load) begin
        chan_free <= 1'b0;
      end else if (tx_done) begin
        chan_free <= 1'b1;
      end

      if (grp_clr) begin
        grp_cnt <= pop ? 4'd1 : 4'd0;
      end else if (pop) begin
        grp_cnt <= grp_cnt + 1'b1;
      end else if (load && sep_due) begin
        grp_cnt <= '0;
      end

`ifdef ENIGMA_NEWLINE_EN
      if (grp_clr) begin
        line_cnt <= '0;
        lf_pend  <= 1'b0;
      end else if (load && lf_pend) begin
        lf_pend <= 1'b0;
      end else if (load && sep_due) begin
        if (line_last) begin
          line_cnt <= '0;
          lf_pend  <= 1'b1;
        end else begin
          line_cnt <= line_cnt + 1'b1;
        end
      end
`endif
    end
  end

  enigma_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .data (tx_char),
    .load (load),
    .tx   (tx),
    .busy (tx_busy),
    .done (tx_done)
  );

endmodule

// File: tb/tb_enigma_out_grouper.sv
// Directed bench for enigma_out_grouper with a UART receiver monitor.
`timescale 1ns/1ps
module tb_enigma_out_grouper;

  localparam int C     = 4;
  localparam int DEPTH = 8;
`ifdef ENIGMA_NEWLINE_EN
  localparam int GL    = 2;
`else
  localparam int GL    = 5;
`endif
  localparam int LG    = 2;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ena = 1'b1;
  logic [4:0]       in_sym = 5'd0;
  logic             in_valid = 1'b0;
  logic             grp_clr = 1'b0;
  logic             in_ready;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             tx;
  logic             tx_busy;

  always #5 clk = ~clk;

  enigma_out_grouper #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (DEPTH),
    .GROUP_LEN   (GL),
    .LINE_GROUPS (LG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_sym    (in_sym),
    .in_valid  (in_valid),
    .grp_clr   (grp_clr),
    .in_ready  (in_ready),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  int checks   = 0;
  int failures = 0;

  // UART receiver model: counts only enabled cycles, samples mid-bit.
  byte unsigned rxq[$];
  int           frame_err = 0;
  bit           rx_on = 1'b0;
  int           rx_cnt = 0;
  logic [7:0]   rx_byte = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_on = 1'b0;
    end else if (ena) begin
      if (!rx_on) begin
        if (tx == 1'b0) begin
          rx_on  = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt = rx_cnt + 1;
        if (rx_cnt >= C && rx_cnt < 9 * C && (rx_cnt % C) == C / 2)
          rx_byte[3'(rx_cnt / C - 1)] = tx;
        if (rx_cnt == 9 * C + C / 2) begin
          if (tx != 1'b1) frame_err = frame_err + 1;
          rxq.push_back(rx_byte);
          rx_on = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [4:0] sym;
    int         exp_level;
    logic       exp_ready;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int sym);
    in_valid = 1'b1;
    in_sym   = 5'(sym);
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    rxq.delete();
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    int quiet;
    quiet = 0;
    ok    = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (fifo_level == 0 && !tx_busy && !rx_on) quiet++;
      else quiet = 0;
      if (quiet >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_stream(input string name, input string exp);
    bit    ok;
    string s;
    wait_idle(4000, ok);
    s = "";
    foreach (rxq[i]) s = $sformatf("%s%c", s, rxq[i]);
    checks++;
    if (!ok || s != exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" (settled=%0d) expected \"%s\"", name, s, ok, exp);
    end
    rxq.delete();
  endtask

  initial begin
    logic [7:0] a_code;
    logic       held;
    bit         frozen;
    string      exp_s;

    a_code = 8'h41;

    // invalid codes, then ten back-to-back letters into an 8-deep FIFO
    vecs[0]  = '{5'd26, 0, 1'b1, 1'b0};
    vecs[1]  = '{5'd31, 0, 1'b1, 1'b0};
    vecs[2]  = '{5'd0,  1, 1'b1, 1'b0};
    vecs[3]  = '{5'd1,  1, 1'b1, 1'b0};
    vecs[4]  = '{5'd2,  2, 1'b1, 1'b0};
    vecs[5]  = '{5'd3,  3, 1'b1, 1'b0};
    vecs[6]  = '{5'd4,  4, 1'b1, 1'b0};
    vecs[7]  = '{5'd5,  5, 1'b1, 1'b0};
    vecs[8]  = '{5'd6,  6, 1'b1, 1'b0};
    vecs[9]  = '{5'd7,  7, 1'b1, 1'b0};
    vecs[10] = '{5'd8,  8, 1'b0, 1'b0};
    vecs[11] = '{5'd9,  8, 1'b0, 1'b1};

    do_reset();
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);

    // single letter: latency, frame bits, busy duration
    push(0);
    check("t1_level", fifo_level, 1);
    check("t1_tx_n1", tx, 1);
    step();
    check("t1_start", tx, 0);
    check("t1_busy", tx_busy, 1);
    for (int i = 0; i < 8; i++) begin
      repeat (C) step();
      check($sformatf("t1_bit%0d", i), tx, a_code[i]);
    end
    repeat (C) step();
    check("t1_stop", tx, 1);
    repeat (3) step();
    check("t1_busy_last", tx_busy, 1);
    step();
    check("t1_busy_end", tx_busy, 0);
    check_stream("t1_stream", "A");

    // table: invalid codes, then overflow run
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_sym   = vecs[i].sym;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_level", i), fifo_level, vecs[i].exp_level);
      check($sformatf("v%0d_ready", i), in_ready, vecs[i].exp_ready);
      check($sformatf("v%0d_ovf", i), overflow, vecs[i].exp_ovf);
    end
    repeat (60) step();
    check("t4_no_tx", rxq.size(), 0);
    check("t4_level", fifo_level, 0);
    for (int i = 2; i < 12; i++) begin
      in_valid = 1'b1;
      in_sym   = vecs[i].sym;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_level", i), fifo_level, vecs[i].exp_level);
      check($sformatf("v%0d_ready", i), in_ready, vecs[i].exp_ready);
      check($sformatf("v%0d_ovf", i), overflow, vecs[i].exp_ovf);
    end
`ifdef ENIGMA_NEWLINE_EN
    exp_s = $sformatf("AB CD%c%cEF GH%c%cI", 8'h0D, 8'h0A, 8'h0D, 8'h0A);
`else
    exp_s = "ABCDE FGHI";
`endif
    check_stream("t3_stream", exp_s);
    check("t3_ovf_sticky", overflow, 1);
    do_reset();
    check("t3_ovf_cleared", overflow, 0);

`ifndef ENIGMA_NEWLINE_EN
    // spaced pushes, grouping with no trailing space
    for (int i = 0; i < 12; i++) begin
      push(i);
      repeat (19) step();
    end
    check_stream("t2_stream", "ABCDE FGHIJ KL");
`endif

    // ena low mid-DATA freezes the line
    do_reset();
    push(0);
    step();
    repeat (8) step();
    ena      = 1'b0;
    in_valid = 1'b1;
    in_sym   = 5'd3;
    held     = tx;
    frozen   = 1'b1;
    repeat (50) begin
      step();
      if (tx !== held || tx_busy !== 1'b1) frozen = 1'b0;
    end
    check("t5_frozen", frozen, 1);
    check("t5_no_push", fifo_level, 0);
    in_valid = 1'b0;
    ena      = 1'b1;
    check_stream("t5_resume", "A");

    // reset mid-frame
    push(1);
    push(2);
    push(3);
    check("t5_pre_rst_tx", tx, 0);
    rst = 1'b1;
    step();
    check("t5_rst_tx", tx, 1);
    check("t5_rst_level", fifo_level, 0);
    check("t5_rst_busy", tx_busy, 0);
    check("t5_rst_ready", in_ready, 1);
    rst = 1'b0;
    repeat (60) step();
    check("t5_abandoned", rxq.size(), 0);
    push(0);
    check_stream("t5_after_rst", "A");

    // grp_clr restarts grouping
    do_reset();
    push(0);
    push(1);
    check_stream("t6_ab", "AB");
    grp_clr = 1'b1;
    step();
    grp_clr = 1'b0;
`ifdef ENIGMA_NEWLINE_EN
    push(2);
    check_stream("t6_clr", "C");
    do_reset();
    for (int i = 0; i < 7; i++) push(i);
    check_stream("t6_newline", $sformatf("AB CD%c%cEF G", 8'h0D, 8'h0A));
`else
    for (int i = 2; i < 8; i++) push(i);
    check_stream("t6_clr", "CDEFG H");
`endif

    check("frame_err", frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/enigma_out_grouper.md
Name: enigma_out_grouper

Overview:
Downstream stage of the Enigma core. It consumes the core's one-cycle (dout, valid) letter pulses and buffers them in a small FIFO. It converts each letter to ASCII, inserts a space after every GROUP_LEN letters (classic 5-letter cipher groups) and transmits the stream on an 8N1 UART line to the board's serial header.

Parameters:
CLKS_PER_BIT, 104, clk cycles per UART bit (enabled cycles only); minimum 4
FIFO_DEPTH, 8, letter FIFO entries; power of 2, minimum 2
GROUP_LEN, 5, letters per group before a separator; range 1..15
LINE_GROUPS, 6, groups per line; used only with ENIGMA_NEWLINE_EN; range 1..15

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ena  in  1  global enable; when low, all state is frozen
in_sym  in  5  letter code 0..25 = A..Z (core dout)
in_valid  in  1  one-cycle strobe, letter present (core valid)
grp_clr  in  1  restart grouping (driven by reset_btn)
in_ready  out  1  FIFO not full; upstream gates confirm with it
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a valid letter was dropped because the FIFO was full
tx  out  1  UART serial out, idle high
tx_busy  out  1  high from start bit through last stop-bit cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst; rst wins over ena.
- Reset values: tx=1, tx_busy=0, in_ready=1, fifo_level=0, overflow=0. FIFO is empty; group count and line count are 0; FSM is in IDLE.
- Reset mid-frame: tx returns high on the next edge and the partial frame is abandoned.
- ena=0: no push, no pop, baud counter holds, tx holds its current level.
- Push: occurs when ena & in_valid & (in_sym<26) & !full.
  - in_sym>=26: silently dropped; overflow is not set.
  - Valid letter while full: dropped and overflow<=1. This holds even if a pop happens in the same cycle (full is sampled before the pop).
  - overflow clears only on rst.
- in_ready = !full, registered view of the current occupancy.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE, FIFO non-empty, grp_cnt==GROUP_LEN: load char 0x20 (no pop); grp_cnt<=0.
  - IDLE, FIFO non-empty, otherwise: pop one letter; load char 0x41+sym; grp_cnt++.
  - The separator is emitted lazily, only when a further letter exists, so there is never a trailing space.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE. Back-to-back frames are allowed, with exactly one IDLE cycle between frames.
- Latency: letter pushed into an empty FIFO in enabled cycle N -> popped in cycle N+1 -> tx falls at the edge ending cycle N+1, so it is low in cycle N+2.
- grp_clr (with ena): grp_cnt<=0 and line_cnt<=0; any pending separator is cancelled.
  - A frame already in flight completes unchanged.
  - If grp_clr coincides with an IDLE load decision, grp_clr takes priority: the letter is loaded and grp_cnt<=1.
- Arithmetic:
  - FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
  - Occupancy is one bit wider than the pointers.
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide, counting 0..CLKS_PER_BIT-1.

Optional Feature:
Macro: ENIGMA_NEWLINE_EN.
- Defined: when a separator is due and line_cnt==LINE_GROUPS-1, send 0x0D then 0x0A (two frames) instead of 0x20, and set line_cnt<=0. Otherwise send 0x20 and line_cnt++. FSM gains an LF-pending flag.
- Undefined: line_cnt logic and LINE_GROUPS are unused; only spaces are ever emitted.

Decomposition:
- Shared package enigma_pkg:
  - ALPHA_N=26
  - sym_t (logic [4:0])
  - ASCII_A=8'h41, ASCII_SP=8'h20, ASCII_CR=8'h0D, ASCII_LF=8'h0A
- Natural sub-module: enigma_uart_tx.
  - Contains the START/DATA/STOP shifter and baud counter.
  - Interface: data[7:0], load, ena -> tx, busy, done.
- The FIFO and the grouping FSM stay in the top module.

Test Plan:
1. Single push sym=0, CLKS_PER_BIT=4 -> tx low in cycle N+2; frame bits 1,0,0,0,0,0,1,0 (0x41 LSB first); stop high; tx_busy low after 40 cycles.
2. Push syms 0..11, spaced to avoid overflow -> decoded UART stream "ABCDE FGHIJ KL"; no trailing space.
3. Ten pushes on consecutive cycles, syms 0..9, FIFO_DEPTH=8 -> sym 9 dropped, overflow=1, in_ready=0 while level=8; stream "ABCDE FGHI".
4. Push sym=26 and sym=31 -> nothing transmitted, fifo_level stays 0, overflow stays 0.
5. ena low for 50 cycles mid-DATA -> tx level frozen, frame resumes intact; rst mid-frame -> tx=1 next cycle, fifo_level=0, subsequent "A" starts with no leading space.
6. With ENIGMA_NEWLINE_EN, LINE_GROUPS=2, GROUP_LEN=2: push 7 letters -> "AB CD\r\nEF G"; grp_clr after "AB" -> next letter sent with no space.
